// File: rtl/mipi_phy_ser_if.sv
// Byte-stream handshake from the packet layer into the D-PHY transmit lane controller.
interface mipi_phy_ser_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/mipi_phy_ser.sv
// D-PHY transmit lane controller: stripes a byte stream across active lanes and sequences
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11, one word per tick.
module mipi_phy_ser #(
    parameter int MAX_LANES    = 1,
    parameter int T_HS_PREPARE = 2,
    parameter int T_HS_ZERO    = 6,
    parameter int T_HS_TRAIL   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             num_active_lanes,
    input  logic [MAX_LANES-1:0]   md_polarity,
    input  logic [7:0]             mipi_tx_period,
    mipi_phy_ser_if.slave          in_if,
    output logic                   tick,
    output logic                   hs_oe,
    output logic [8*MAX_LANES-1:0] hs_data,
    output logic [MAX_LANES-1:0]   mdp_lp,
    output logic [MAX_LANES-1:0]   mdn_lp,
    output logic                   busy,
    output logic                   underrun
);
    typedef enum logic [2:0] {
        ST_STOP, ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL, ST_EXIT
    } state_t;

    localparam logic [2:0] TLAST     = 3'(MAX_LANES - 1);
    localparam logic [7:0] PREP_END  = 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] ZERO_END  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] TRAIL_END = 8'(T_HS_TRAIL - 1);

    state_t                        state_q, state_d;
    logic [7:0]                    timer_q, timer_d;
    logic [2:0]                    tcnt_q, tcnt_d;
    logic [2:0]                    nl_q, nl_in;
    logic [MAX_LANES-1:0]          act;
    logic [MAX_LANES-1:0][7:0]     asm_q;
    logic [2:0]                    acnt_q, acnt_base;
    logic                          closed_q, closed_base;
    logic                          hs_st, take, fire;
    logic [MAX_LANES-1:0]          b0_q, b0_d;
    logic [MAX_LANES-1:0]          lpp_d, lpn_d;
    logic [MAX_LANES-1:0][7:0]     word_d, hs_d, trail_w;
    logic                          oe_d, urun_d;

    // Free-running word counter; tick is registered so it is low while in reset.
    assign tcnt_d = (tcnt_q == TLAST) ? 3'd0 : tcnt_q + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= 3'd0;
            tick   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tick   <= (tcnt_d == TLAST);
        end
    end

    always_comb begin
        nl_in = num_active_lanes;
        if (num_active_lanes == 3'd0)                 nl_in = 3'd1;
        else if (num_active_lanes > 3'(MAX_LANES))    nl_in = 3'(MAX_LANES);
    end

    always_comb begin
        for (int k = 0; k < MAX_LANES; k++) begin
            act[k]     = (3'(k) < nl_q);
            trail_w[k] = {8{~b0_q[k]}};
        end
    end

    // A full word may be refilled on the very tick it is shipped; a short one may not,
    // so a byte can never slip in behind an underrun close.
    assign hs_st           = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign take            = tick && (state_q == ST_DATA);
    assign in_if.in_ready  = hs_st && !closed_q && (take ? (acnt_q == nl_q) : (acnt_q < nl_q));
    assign fire            = in_if.in_valid && in_if.in_ready;
    assign acnt_base       = take ? 3'd0 : acnt_q;
    assign closed_base     = take ? 1'b0 : closed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q    <= '0;
            acnt_q   <= 3'd0;
            closed_q <= 1'b0;
            nl_q     <= 3'd1;
        end else begin
            if (state_q == ST_STOP) nl_q <= nl_in;
            if (!hs_st) begin
                acnt_q   <= 3'd0;
                closed_q <= 1'b0;
            end else begin
                acnt_q   <= acnt_base + {2'b00, fire};
                closed_q <= closed_base | (fire & in_if.in_last);
                for (int k = 0; k < MAX_LANES; k++)
                    if (fire && acnt_base == 3'(k)) asm_q[k] <= in_if.in_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 8'd1;
        oe_d    = 1'b0;
        lpp_d   = '1;
        lpn_d   = '1;
        word_d  = '0;
        b0_d    = b0_q;
        urun_d  = 1'b0;
        case (state_q)
            ST_STOP: if (in_if.in_valid) begin
                state_d = ST_LPX;
                timer_d = 8'd0;
            end
            ST_LPX: begin
                lpp_d = ~act;
                if (timer_q == mipi_tx_period) begin state_d = ST_PREP; timer_d = 8'd0; end
            end
            ST_PREP: begin
                lpp_d = ~act;
                lpn_d = ~act;
                if (timer_q == PREP_END) begin state_d = ST_ZERO; timer_d = 8'd0; end
            end
            ST_ZERO: begin
                lpp_d = ~act;
                lpn_d = ~act;
                oe_d  = 1'b1;
                if (timer_q == ZERO_END) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                lpp_d   = ~act;
                lpn_d   = ~act;
                oe_d    = 1'b1;
                word_d  = {MAX_LANES{8'hB8}};
                b0_d    = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                lpp_d = ~act;
                lpn_d = ~act;
                oe_d  = 1'b1;
                for (int k = 0; k < MAX_LANES; k++) begin
                    if (3'(k) < acnt_q) begin
                        word_d[k] = asm_q[k];
                        b0_d[k]   = asm_q[k][0];
                    end else begin
                        word_d[k] = trail_w[k];
                    end
                end
                // A short unclosed word is shipped as if in_last had arrived.
                if (closed_q || acnt_q < nl_q) begin
                    state_d = ST_TRAIL;
                    timer_d = 8'd0;
                    urun_d  = !closed_q;
                end
            end
            ST_TRAIL: begin
                lpp_d  = ~act;
                lpn_d  = ~act;
                oe_d   = 1'b1;
                word_d = trail_w;
                if (timer_q == TRAIL_END) begin state_d = ST_EXIT; timer_d = 8'd0; end
            end
            ST_EXIT: if (timer_q == mipi_tx_period) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
        for (int k = 0; k < MAX_LANES; k++)
            hs_d[k] = (oe_d && act[k]) ? (word_d[k] ^ {8{md_polarity[k]}}) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_STOP;
            timer_q  <= 8'd0;
            hs_oe    <= 1'b0;
            hs_data  <= '0;
            mdp_lp   <= '1;
            mdn_lp   <= '1;
            b0_q     <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= tick & urun_d;
            if (tick) begin
                state_q <= state_d;
                timer_q <= timer_d;
                hs_oe   <= oe_d;
                hs_data <= hs_d;
                mdp_lp  <= lpp_d;
                mdn_lp  <= lpn_d;
                b0_q    <= b0_d;
            end
        end
    end

    assign busy = (state_q != ST_STOP);
endmodule

// File: tb/tb_mipi_phy_ser.sv
// Directed bench for mipi_phy_ser (two lanes): per-tick output trace against hand-built frames.
module tb_mipi_phy_ser;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  nal;
    logic [1:0]  pol;
    logic [7:0]  per;
    logic        tick, hs_oe, busy, underrun;
    logic [15:0] hs_data;
    logic [1:0]  mdp_lp, mdn_lp;

    mipi_phy_ser_if bus();

    mipi_phy_ser #(.MAX_LANES(2), .T_HS_PREPARE(2), .T_HS_ZERO(6), .T_HS_TRAIL(4)) dut (
        .clk(clk), .reset(reset), .num_active_lanes(nal), .md_polarity(pol),
        .mipi_tx_period(per), .in_if(bus), .tick(tick), .hs_oe(hs_oe), .hs_data(hs_data),
        .mdp_lp(mdp_lp), .mdn_lp(mdn_lp), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_urun;
    logic [1:0]  act_e;
    logic [8:0]  srcq[$];
    logic [20:0] trace[$];
    logic [20:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // One clock: present the source head, log outputs after every tick edge.
    task automatic cyc();
        logic fire, was_tick;
        @(negedge clk);
        if (srcq.size() > 0) begin
            bus.in_valid = 1'b1;
            {bus.in_last, bus.in_data} = srcq[0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            bus.in_data  = 8'h00;
        end
        fire     = bus.in_valid && bus.in_ready;
        was_tick = tick;
        @(posedge clk);
        #1;
        if (fire) void'(srcq.pop_front());
        if (was_tick) trace.push_back({hs_oe, mdp_lp, mdn_lp, hs_data});
        if (underrun) n_urun++;
    endtask

    task automatic px(input logic oe, input logic [1:0] p, input logic [1:0] n, input logic [15:0] d);
        expq.push_back({oe, p, n, d});
    endtask

    function automatic logic [15:0] pw(input logic [15:0] w);
        logic [15:0] r;
        r = w ^ {{8{pol[1]}}, {8{pol[0]}}};
        if (!act_e[1]) r[15:8] = 8'h00;
        if (!act_e[0]) r[7:0]  = 8'h00;
        return r;
    endfunction

    task automatic frame_head(input int p);
        expq.delete();
        px(1'b0, 2'b11, 2'b11, 16'h0);
        repeat (p + 1) px(1'b0, ~act_e, 2'b11, 16'h0);
        repeat (2)     px(1'b0, ~act_e, ~act_e, 16'h0);
        repeat (6)     px(1'b1, ~act_e, ~act_e, pw(16'h0000));
        px(1'b1, ~act_e, ~act_e, pw(16'hB8B8));
    endtask

    task automatic frame_data(input logic [15:0] w);
        px(1'b1, ~act_e, ~act_e, pw(w));
    endtask

    task automatic frame_tail(input logic [15:0] trail, input int p);
        repeat (4)     frame_data(trail);
        repeat (p + 1) px(1'b0, 2'b11, 2'b11, 16'h0);
        px(1'b0, 2'b11, 2'b11, 16'h0);
    endtask

    task automatic run_frame(input string name);
        int budget;
        budget = 0;
        trace.delete();
        n_urun = 0;
        while (trace.size() < expq.size() && budget < 600) begin
            cyc();
            budget++;
        end
        chk({name, "_len"}, trace.size(), expq.size());
        foreach (expq[i])
            if (i < trace.size()) chk($sformatf("%s[%0d]", name, i), 32'(trace[i]), 32'(expq[i]));
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ticks, budget;
        reset = 1'b1; nal = 3'd1; pol = 2'b00; per = 8'd3;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oe", 32'(hs_oe), 0);
        chk("rst_data", 32'(hs_data), 0);
        chk("rst_mdp", 32'(mdp_lp), 32'h3);
        chk("rst_mdn", 32'(mdn_lp), 32'h3);
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_urun", 32'(underrun), 0);
        chk("rst_tick", 32'(tick), 0);
        reset = 1'b0;

        ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        chk("tick_rate", ticks, 10);

        // 1: single active lane (0 treated as 1), 0x33 ends in b0=1 -> trail 0x00
        nal = 3'd0; act_e = 2'b01; per = 8'd3;
        srcq = '{9'h011, 9'h022, 9'h133};
        frame_head(3);
        frame_data(16'h0011); frame_data(16'h0022); frame_data(16'h0033);
        frame_tail(16'h0000, 3);
        run_frame("t1");
        chk("t1_urun", n_urun, 0);

        // 2: two lanes, round-robin striping
        nal = 3'd2; act_e = 2'b11; per = 8'd2;
        srcq = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
        frame_head(2);
        frame_data(16'h0201); frame_data(16'h0403); frame_data(16'h0605);
        frame_tail(16'hFF00, 2);
        run_frame("t2");
        chk("t2_urun", n_urun, 0);

        // 3: last byte mid-word, lane1 filled with its trail pattern
        srcq = '{9'h0A0, 9'h0A1, 9'h1A2};
        frame_head(2);
        frame_data(16'hA1A0); frame_data(16'h00A2);
        frame_tail(16'h00FF, 2);
        run_frame("t3");
        chk("t3_urun", n_urun, 0);

        // 4: source dries up with one byte pending -> underrun, byte still sent
        srcq = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
        frame_head(2);
        frame_data(16'h0201); frame_data(16'h0403); frame_data(16'hFF05);
        frame_tail(16'hFF00, 2);
        run_frame("t4");
        chk("t4_urun", n_urun, 1);

        // 5: lane0 inverted
        pol = 2'b01;
        srcq = '{9'h001, 9'h002, 9'h003, 9'h104};
        frame_head(2);
        frame_data(16'h0201); frame_data(16'h0403);
        frame_tail(16'hFF00, 2);
        run_frame("t5");
        if (trace.size() > 13) begin
            chk("t5_sync_l0", 32'(trace[12][7:0]), 32'h47);
            chk("t5_recover", 32'(trace[13][7:0] ^ 8'hFF), 32'h01);
        end else chk("t5_trace_short", trace.size(), 14);

        // 6: reset while sending payload, then a clean burst (lanes=7 clamps to 2)
        pol = 2'b00; nal = 3'd7;
        srcq = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006};
        trace.delete();
        budget = 0;
        while (trace.size() < 14 && budget < 300) begin cyc(); budget++; end
        chk("t6_pre_len", trace.size(), 14);
        if (trace.size() > 13) chk("t6_pre_word", 32'(trace[13]), 32'({1'b1, 2'b00, 2'b00, 16'h0201}));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_oe", 32'(hs_oe), 0);
        chk("t6_mdp", 32'(mdp_lp), 32'h3);
        chk("t6_mdn", 32'(mdn_lp), 32'h3);
        chk("t6_ready", 32'(bus.in_ready), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_data", 32'(hs_data), 0);
        @(negedge clk);
        reset = 1'b0;
        srcq = '{9'h0B1, 9'h0B2, 9'h0B3, 9'h1B4};
        frame_head(2);
        frame_data(16'hB2B1); frame_data(16'hB4B3);
        frame_tail(16'hFF00, 2);
        run_frame("t6");
        chk("t6_urun", n_urun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
